pixel_plot_queue: RTL

//  Downstream stage of the line-drawing datapath. Buffers the (x, y, colour) pixel stream

---
 rtl/line_draw_pkg.sv | 21 ++
 rtl/pixel_plot_queue_if.sv | 27 ++
 rtl/pixel_fifo_mem.sv | 25 ++
 rtl/pixel_plot_queue.sv | 101 ++++++++++
 4 files changed

// File: rtl/line_draw_pkg.sv
// Shared types and screen constants for the line-drawing datapath.
package line_draw_pkg;

  localparam int unsigned X_W      = 9;
  localparam int unsigned Y_W      = 8;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // True when the pixel lies inside the visible screen area.
  function automatic logic in_screen(input pixel_t p);
    return (32'(p.x) < SCREEN_W) && (32'(p.y) < SCREEN_H);
  endfunction

endpackage

// File: rtl/pixel_plot_queue_if.sv
// Pixel stream from the stepper plus the VGA adapter write port.
// master: stepper/adapter side; slave: the plot queue.
interface pixel_plot_queue_if;
  import line_draw_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [X_W-1:0]      in_x;
  logic [Y_W-1:0]      in_y;
  logic [COLOUR_W-1:0] in_colour;
  logic                vga_busy;
  logic                vga_plot;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;

  modport master (
    output in_valid, in_x, in_y, in_colour, vga_busy,
    input  in_ready, vga_plot, vga_x, vga_y, vga_colour
  );

  modport slave (
    input  in_valid, in_x, in_y, in_colour, vga_busy,
    output in_ready, vga_plot, vga_x, vga_y, vga_colour
  );

endinterface

// File: rtl/pixel_fifo_mem.sv
// DEPTH x pixel_t storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the occupancy level in the parent gates every read.
module pixel_fifo_mem
  import line_draw_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  pixel_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output pixel_t                   rdata
);

  pixel_t mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_plot_queue.sv
// Buffers the Bresenham pixel stream and replays it to the VGA adapter as
// single-cycle plot strobes, absorbing adapter back-pressure.
// Optional feature macro: PIXEL_CLIP_EN -- off-screen pixels are accepted but
// not stored, and counted in drop_cnt (saturating).
module pixel_plot_queue
  import line_draw_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pixel_plot_queue_if.slave      pif,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle,
  output logic [15:0]            drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             push;
  logic             store;
  logic             pop;
  pixel_t           in_px;
  pixel_t           rd_px;
  logic             plot_q;
  pixel_t           out_q;

  assign in_px = '{x: pif.in_x, y: pif.in_y, colour: pif.in_colour};

  // Full blocks writes outright; a same-edge pop never frees a slot early.
  assign full         = (level == LVL_W'(DEPTH));
  assign pif.in_ready = !full;
  assign push         = pif.in_valid && !full;
  assign pop          = (level != '0) && !pif.vga_busy;

`ifdef PIXEL_CLIP_EN
  logic clip;
  assign clip  = push && !in_screen(in_px);
  assign store = push && !clip;
`else
  assign store = push;
`endif

  pixel_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (in_px),
    .raddr (rd_ptr),
    .rdata (rd_px)
  );

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({store, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Plot strobe lasts one cycle; coordinates hold between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      plot_q <= 1'b0;
      out_q  <= '0;
    end else begin
      plot_q <= pop;
      if (pop) out_q <= rd_px;
    end
  end

  assign pif.vga_plot   = plot_q;
  assign pif.vga_x      = out_q.x;
  assign pif.vga_y      = out_q.y;
  assign pif.vga_colour = out_q.colour;
  assign idle           = (level == '0) && !plot_q;

`ifdef PIXEL_CLIP_EN
  // Saturating count of clipped pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    drop_cnt <= '0;
    else if (clip && drop_cnt != '1) drop_cnt <= drop_cnt + 16'(1);
  end
`else
  assign drop_cnt = '0;
`endif

endmodule
